// File: rtl/led_demux_sequencer_pkg.sv
// Shared widths and helpers for the LED demux sequencer: selection width,
// LED count, selection stepping and the one-hot LED decode.
package led_demux_sequencer_pkg;

    localparam int SEL_W     = 2;
    localparam int LED_COUNT = 4;

    typedef logic [SEL_W-1:0]     sel_t;
    typedef logic [LED_COUNT-1:0] led_vec_t;

    // Simultaneous forward and backward releases cancel each other out.
    function automatic sel_t next_sel(input sel_t sel, input logic fwd, input logic back);
        case ({fwd, back})
            2'b10:   return sel + sel_t'(1);
            2'b01:   return sel - sel_t'(1);
            default: return sel;
        endcase
    endfunction

    function automatic led_vec_t led_decode(input sel_t sel, input logic blink);
        led_vec_t v;
        v      = '0;
        v[sel] = blink;
        return v;
    endfunction

endpackage

// File: rtl/led_demux_sequencer_if.sv
// Switch/LED bundle of the sequencer: the switch side drives the raw switches,
// the LED side returns the four demultiplexed outputs.
interface led_demux_sequencer_if;
    import led_demux_sequencer_pkg::*;

    logic     switch_1;
    logic     switch_2;
    logic     led_1;
    logic     led_2;
    logic     led_3;
    logic     led_4;
    led_vec_t led;

    assign led = {led_4, led_3, led_2, led_1};

    modport master (
        output switch_1, switch_2,
        input  led_1, led_2, led_3, led_4, led
    );

    modport slave (
        input  switch_1, switch_2,
        output led_1, led_2, led_3, led_4
    );

endinterface

// File: rtl/led_demux_sequencer_debounce_filter.sv
// Switch debouncer: the output level follows the raw input only after the raw
// level has differed from it for DEBOUNCE_LIMIT consecutive clocks.
module debounce_filter #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Raw,
    output logic o_Level
);

    localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [CNT_W-1:0] count;

    // Any return to the accepted level throws away the partial count.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            count   <= '0;
            o_Level <= 1'b0;
        end else if (i_Raw != o_Level) begin
            if (count == CNT_LAST) begin
                o_Level <= i_Raw;
                count   <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/led_demux_sequencer.sv
// Two debounced switches step a 2-bit selection forward/backward; the selected
// LED of four carries a free-running blink, all others stay dark.
module led_demux_sequencer
    import led_demux_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int TOGGLE_LIMIT   = 12500000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_LED_1,
    output logic o_LED_2,
    output logic o_LED_3,
    output logic o_LED_4
);

    localparam int BLINK_W = (TOGGLE_LIMIT > 1) ? $clog2(TOGGLE_LIMIT) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(TOGGLE_LIMIT - 1);

    logic               level_1;
    logic               level_2;
    logic               level_1_p1;
    logic               level_2_p1;
    logic               release_1;
    logic               release_2;
    sel_t               sel;
    logic [BLINK_W-1:0] blink_count;
    logic               blink;
    led_vec_t           led;

    debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_debounce_1 (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Raw   (i_Switch_1),
        .o_Level (level_1)
    );

    debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_debounce_2 (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Raw   (i_Switch_2),
        .o_Level (level_2)
    );

    // Release = debounced level was 1 last clock and is 0 now; both reset to 0,
    // so reset can never manufacture a release.
    assign release_1 = level_1_p1 & ~level_1;
    assign release_2 = level_2_p1 & ~level_2;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            level_1_p1 <= 1'b0;
            level_2_p1 <= 1'b0;
            sel        <= '0;
        end else begin
            level_1_p1 <= level_1;
            level_2_p1 <= level_2;
            sel        <= next_sel(sel, release_1, release_2);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            blink_count <= '0;
            blink       <= 1'b0;
        end else if (blink_count == BLINK_LAST) begin
            blink_count <= '0;
            blink       <= ~blink;
        end else begin
            blink_count <= blink_count + 1'b1;
        end
    end

    // Output stage: a newly selected LED picks up the current blink phase.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            led <= '0;
        end else begin
            led <= led_decode(sel, blink);
        end
    end

    assign o_LED_1 = led[0];
    assign o_LED_2 = led[1];
    assign o_LED_3 = led[2];
    assign o_LED_4 = led[3];

endmodule

// File: tb/tb_led_demux_sequencer.sv
// Directed bench for led_demux_sequencer with DEBOUNCE_LIMIT=4, TOGGLE_LIMIT=3.
module tb_led_demux_sequencer;
    import led_demux_sequencer_pkg::*;

    localparam int DL = 4;
    localparam int TL = 3;

    typedef struct {
        logic       sw1;
        logic       sw2;
        logic [3:0] led;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n;
    vec_t tbl[12];

    led_demux_sequencer_if bus();

    led_demux_sequencer #(
        .DEBOUNCE_LIMIT (DL),
        .TOGGLE_LIMIT   (TL)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Switch_1 (bus.switch_1),
        .i_Switch_2 (bus.switch_2),
        .o_LED_1    (bus.led_1),
        .o_LED_2    (bus.led_2),
        .o_LED_3    (bus.led_3),
        .o_LED_4    (bus.led_4)
    );

    always #5 clk = ~clk;

    // Edges seen since reset released; drives the expected blink phase.
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    always @(negedge clk) begin
        checks++;
        assert ($countones(bus.led) <= 1) else begin
            failures++;
            $display("FAIL onehot: led=%b has more than one bit set", bus.led);
        end
    end

    // Blink bit after edge k: toggles at edges TL, 2*TL, ...
    function automatic logic [3:0] exp_led(input int sel, input int k);
        logic b;
        b = (k <= 0) ? 1'b0 : (((k / TL) % 2) == 1);
        return b ? (4'b0001 << sel) : 4'b0000;
    endfunction

    task automatic check(input string name, input logic [3:0] exp);
        checks++;
        if (bus.led !== exp) begin
            failures++;
            $display("FAIL %s: led=%b expected=%b (edge %0d)", name, bus.led, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_chk(input string name, input int sel);
        step();
        check(name, exp_led(sel, n - 1));
    endtask

    // Hold the switches for 6 clocks, release for 6; the LED move lands on the 6th release clock.
    task automatic press_release(input logic s1, input logic s2,
                                 input int from_sel, input int to_sel, input string name);
        bus.switch_1 = s1;
        bus.switch_2 = s2;
        repeat (6) step_chk({name, "_press"}, from_sel);
        bus.switch_1 = 1'b0;
        bus.switch_2 = 1'b0;
        for (int k = 1; k <= 6; k++)
            step_chk({name, "_release"}, (k == 6) ? to_sel : from_sel);
    endtask

    initial begin
        logic [6:0] bounce;

        for (int i = 0; i < 12; i++) begin
            tbl[i].sw1 = 1'b0;
            tbl[i].sw2 = 1'b0;
            tbl[i].led = ((i % 6) >= 3) ? 4'b0001 : 4'b0000;
        end

        bus.switch_1 = 1'b0;
        bus.switch_2 = 1'b0;
        #2;
        check("reset_before_edge", 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus.switch_1 = tbl[i].sw1;
            bus.switch_2 = tbl[i].sw2;
            step();
            check($sformatf("blink[%0d]", i), tbl[i].led);
        end

        press_release(1'b1, 1'b0, 0, 1, "fwd_0_1");
        press_release(1'b1, 1'b0, 1, 2, "fwd_1_2");
        press_release(1'b1, 1'b0, 2, 3, "fwd_2_3");
        press_release(1'b1, 1'b0, 3, 0, "fwd_3_0");

        press_release(1'b0, 1'b1, 0, 3, "back_0_3");
        press_release(1'b1, 1'b1, 3, 3, "both");
        repeat (6) step_chk("both_hold", 3);

        bounce = 7'b0111011;
        for (int i = 0; i < 7; i++) begin
            bus.switch_1 = bounce[6 - i];
            step_chk("bounce", 3);
        end
        repeat (8) step_chk("bounce_settle", 3);
        press_release(1'b1, 1'b0, 3, 0, "after_bounce");

        press_release(1'b1, 1'b0, 0, 1, "to_1");
        press_release(1'b1, 1'b0, 1, 2, "to_2");
        for (int w = 0; w < 6 && exp_led(2, n + 1) == 4'b0000; w++)
            step_chk("pre_rst", 2);
        bus.switch_1 = 1'b1;
        repeat (2) step_chk("mid_debounce", 2);
        #2 rst = 1'b1;
        #1 check("async_rst", 4'b0000);
        bus.switch_1 = 1'b0;
        @(negedge clk);
        check("rst_held", 4'b0000);
        rst = 1'b0;
        repeat (12) step_chk("post_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
